// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational 32-bit logic ALU.
// Holds registered operands for ALU_LAT cycles, then returns result and flags with the requester id.
module alu_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int MAX_SEL = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_A,
   input  logic [63:0] req_B,
   input  logic [7:0]  req_sel,
   input  logic [1:0]  req_Cin,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_sel,
   output logic        alu_Cin,
   input  logic [31:0] alu_Y,
   input  logic        alu_Cout,
   input  logic        alu_Negative,
   input  logic        alu_Zero,
   input  logic        alu_Overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_Y,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] MAX_SEL_C = 4'(MAX_SEL);
   localparam logic [3:0] LAT_INIT  = 4'(ALU_LAT - 1);

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        grant;
   logic        accept;
   logic        op_id;
   logic [3:0]  cnt;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_sel;
   logic        op_cin;
   logic        op_illegal;

   // Grant selection: with both requesting, the one not served last wins.
   always_comb begin
      if (req_valid == 2'b11) begin
         grant = ~last_grant;
      end else begin
         grant = ~req_valid[0];
      end
      accept     = (state == IDLE) && (req_valid != 2'b00);
      op_a       = grant ? req_A[63:32]  : req_A[31:0];
      op_b       = grant ? req_B[63:32]  : req_B[31:0];
      op_sel     = grant ? req_sel[7:4]  : req_sel[3:0];
      op_cin     = grant ? req_Cin[1]    : req_Cin[0];
      op_illegal = (op_sel > MAX_SEL_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 2'b00;
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready[grant] = 1'b1;
               state_next       = op_illegal ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (cnt == 4'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rsp_valid = (state == RESP);

   // Illegal ops bypass the ALU, so the operand registers keep the previous op and do not toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_id      <= 1'b0;
         cnt        <= 4'd0;
         alu_A      <= 32'd0;
         alu_B      <= 32'd0;
         alu_sel    <= 4'd0;
         alu_Cin    <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_Y      <= 32'd0;
         rsp_flags  <= 4'd0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= grant;
                  op_id      <= grant;
                  if (op_illegal) begin
                     rsp_id    <= grant;
                     rsp_err   <= 1'b1;
                     rsp_Y     <= 32'd0;
                     rsp_flags <= 4'd0;
                  end else begin
                     alu_A   <= op_a;
                     alu_B   <= op_b;
                     alu_sel <= op_sel;
                     alu_Cin <= op_cin;
                     cnt     <= LAT_INIT;
                  end
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_id    <= op_id;
                  rsp_Y     <= alu_Y;
                  rsp_flags <= {alu_Cout, alu_Negative, alu_Zero, alu_Overflow};
                  rsp_err   <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops with hand-computed results, checked by a
// response monitor; a second instance with ALU_LAT=3 covers the operand-hold latency.
module tb_alu_arbiter;

   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_A;
   logic [63:0] req_B;
   logic [7:0]  req_sel;
   logic [1:0]  req_Cin;
   logic [31:0] alu_A, alu_B, alu_Y;
   logic [3:0]  alu_sel;
   logic        alu_Cin, alu_Cout, alu_Negative, alu_Zero, alu_Overflow;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0] rsp_Y;
   logic [3:0]  rsp_flags;

   logic        t3_rst;
   logic [1:0]  t3_req_valid;
   logic [1:0]  t3_req_ready;
   logic [63:0] t3_req_A;
   logic [63:0] t3_req_B;
   logic [7:0]  t3_req_sel;
   logic [1:0]  t3_req_Cin;
   logic [31:0] t3_alu_A, t3_alu_B, t3_alu_Y;
   logic [3:0]  t3_alu_sel;
   logic        t3_alu_Cin, t3_alu_Cout, t3_alu_Negative, t3_alu_Zero, t3_alu_Overflow;
   logic        t3_rsp_valid, t3_rsp_ready, t3_rsp_id, t3_rsp_err;
   logic [31:0] t3_rsp_Y;
   logic [3:0]  t3_rsp_flags;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_acc = 0;
   exp_t exp_q0[$];
   exp_t exp_q1[$];
   logic grant_log[$];

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
      case (s)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return ~a;
         4'd3:    return ~(a | b);
         4'd4:    return a ^ b;
         4'd5:    return ~(a & b);
         default: return 32'd0;
      endcase
   endfunction

   // Stand-in ALU: Cout echoes Cin and Overflow mirrors sel[0] so every flag bit is observable.
   assign alu_Y        = alu_f(alu_A, alu_B, alu_sel);
   assign alu_Cout     = alu_Cin;
   assign alu_Negative = alu_Y[31];
   assign alu_Zero     = (alu_Y == 32'd0);
   assign alu_Overflow = alu_sel[0];

   assign t3_alu_Y        = alu_f(t3_alu_A, t3_alu_B, t3_alu_sel);
   assign t3_alu_Cout     = t3_alu_Cin;
   assign t3_alu_Negative = t3_alu_Y[31];
   assign t3_alu_Zero     = (t3_alu_Y == 32'd0);
   assign t3_alu_Overflow = t3_alu_sel[0];

   alu_arbiter #(.ALU_LAT(1), .MAX_SEL(5)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_sel(req_sel), .req_Cin(req_Cin),
      .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Cin(alu_Cin),
      .alu_Y(alu_Y), .alu_Cout(alu_Cout), .alu_Negative(alu_Negative),
      .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_Y(rsp_Y), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
   );

   alu_arbiter #(.ALU_LAT(3), .MAX_SEL(5)) u_dut3 (
      .clk(clk), .rst(t3_rst),
      .req_valid(t3_req_valid), .req_ready(t3_req_ready),
      .req_A(t3_req_A), .req_B(t3_req_B), .req_sel(t3_req_sel), .req_Cin(t3_req_Cin),
      .alu_A(t3_alu_A), .alu_B(t3_alu_B), .alu_sel(t3_alu_sel), .alu_Cin(t3_alu_Cin),
      .alu_Y(t3_alu_Y), .alu_Cout(t3_alu_Cout), .alu_Negative(t3_alu_Negative),
      .alu_Zero(t3_alu_Zero), .alu_Overflow(t3_alu_Overflow),
      .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_id(t3_rsp_id),
      .rsp_Y(t3_rsp_Y), .rsp_flags(t3_rsp_flags), .rsp_err(t3_rsp_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Response monitor: pops the expectation of whichever requester the response names.
   always @(negedge clk) begin
      exp_t e;
      if (req_ready != 2'b00) grant_log.push_back(req_ready[1]);
      if (req_valid == 2'b11) chk("ready_not_both", 64'(req_ready == 2'b11), 64'd0);
      if (rsp_valid && rsp_ready) begin
         if ((rsp_id ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: id %0d Y %0h with no op outstanding", rsp_id, rsp_Y);
         end else begin
            e = rsp_id ? exp_q1.pop_front() : exp_q0.pop_front();
            chk($sformatf("rsp_Y_id%0d", rsp_id), 64'(rsp_Y), 64'(e.y));
            chk($sformatf("rsp_flags_id%0d", rsp_id), 64'(rsp_flags), 64'(e.f));
            chk($sformatf("rsp_err_id%0d", rsp_id), 64'(rsp_err), 64'(e.err));
         end
      end
   end

   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic cin, input logic push,
                        input logic [31:0] ey, input logic [3:0] ef, input logic ee);
      int   n;
      exp_t e;
      if (push) begin
         e.y = ey; e.f = ef; e.err = ee;
         if (id == 0) exp_q0.push_back(e);
         else exp_q1.push_back(e);
      end
      req_A[id*32 +: 32] = a;
      req_B[id*32 +: 32] = b;
      req_sel[id*4 +: 4] = s;
      req_Cin[id]        = cin;
      req_valid[id]      = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[id] && n < 100);
      chk($sformatf("accept_req%0d", id), 64'(req_ready[id]), 64'd1);
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", 64'(n < 200), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc3;
      logic [3:0] pat;
      rst = 1'b1; req_valid = 2'b00; req_A = '0; req_B = '0; req_sel = '0; req_Cin = '0;
      rsp_ready = 1'b1;
      t3_rst = 1'b1; t3_req_valid = 2'b00; t3_req_A = '0; t3_req_B = '0; t3_req_sel = '0;
      t3_req_Cin = '0; t3_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_Y}), 64'd0);
      chk("reset_alu", 64'({alu_Cin, alu_sel, alu_B}), 64'd0);
      chk("reset_alu_A", 64'(alu_A), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; t3_rst = 1'b0;

      // Single legal op from requester 0.
      issue(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0, 1'b0, 1'b1, 32'hF000_F000, 4'b0100, 1'b0);
      do @(negedge clk); while (!rsp_valid && (cyc - last_acc) < 20);
      chk("single_latency", 64'(cyc - last_acc), 64'd1);
      chk("single_rsp_id", 64'(rsp_id), 64'd0);
      wait_drain();

      // Illegal select from requester 1: no ALU use, direct response.
      issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 1'b1, 1'b1, 32'd0, 4'd0, 1'b1);
      @(negedge clk);
      chk("illegal_direct_rsp", 64'(rsp_valid), 64'd1);
      chk("illegal_alu_sel_kept", 64'(alu_sel), 64'd0);
      chk("illegal_alu_A_kept", 64'(alu_A), 64'hF0F0_F0F0);
      chk("illegal_rsp_id", 64'(rsp_id), 64'd1);
      wait_drain();

      // Contention: both requesters keep two ops each queued up.
      grant_log.delete();
      fork
         begin
            issue(0, 32'h1234_5678, 32'h0F0F_0000, 4'd1, 1'b1, 1'b1, 32'h1F3F_5678, 4'b1001, 1'b0);
            issue(0, 32'h0000_0000, 32'h0000_0000, 4'd1, 1'b0, 1'b1, 32'h0000_0000, 4'b0011, 1'b0);
         end
         begin
            issue(1, 32'hAAAA_5555, 32'hFFFF_0000, 4'd4, 1'b0, 1'b1, 32'h5555_5555, 4'b0000, 1'b0);
            issue(1, 32'h8000_0000, 32'h0000_0001, 4'd4, 1'b1, 1'b1, 32'h8000_0001, 4'b1100, 1'b0);
         end
      join
      wait_drain();
      chk("grant_count", 64'(grant_log.size()), 64'd4);
      pat = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         if (i < grant_log.size()) chk($sformatf("grant_order%0d", i), 64'(grant_log[i]), 64'(pat[i]));
      end

      // Backpressure with a second requester waiting.
      rsp_ready = 1'b0;
      issue(0, 32'h0F0F_0F0F, 32'h00FF_00FF, 4'd3, 1'b0, 1'b1, 32'hF000_F000, 4'b0101, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      fork
         issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b0, 1'b1, 32'd0, 4'b0011, 1'b0);
      join_none
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_Y", 64'(rsp_Y), 64'hF000_F000);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_drain();

      // Reset while an op from requester 0 is executing.
      issue(0, 32'h0000_0001, 32'h0000_0001, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_Y}), 64'd0);
      chk("rst_exec_alu", 64'({alu_Cin, alu_sel, alu_A}), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      grant_log.delete();
      fork
         issue(0, 32'hFFFF_0000, 32'h0000_0000, 4'd2, 1'b0, 1'b1, 32'h0000_FFFF, 4'b0000, 1'b0);
         issue(1, 32'hFFFF_FFFF, 32'h1234_5678, 4'd0, 1'b0, 1'b1, 32'h1234_5678, 4'b0000, 1'b0);
      join
      wait_drain();
      if (grant_log.size() > 0) chk("post_rst_first_grant", 64'(grant_log[0]), 64'd0);
      else chk("post_rst_grant_seen", 64'(grant_log.size()), 64'd2);

      // ALU_LAT=3 instance: operands held three cycles, response three edges after accept.
      t3_req_A[31:0] = 32'h0000_FFFF; t3_req_B[31:0] = 32'h0000_0000;
      t3_req_sel[3:0] = 4'd2; t3_req_Cin[0] = 1'b0; t3_req_valid[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!t3_req_ready[0] && n < 20);
      chk("lat3_accept", 64'(t3_req_ready[0]), 64'd1);
      acc3 = cyc + 1;
      @(posedge clk); #1;
      t3_req_valid[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("lat3_hold_A", 64'(t3_alu_A), 64'h0000_FFFF);
         chk("lat3_hold_B_sel", 64'({t3_alu_B, t3_alu_sel}), 64'h2);
         chk("lat3_no_rsp_yet", 64'(t3_rsp_valid), 64'd0);
      end
      @(negedge clk);
      chk("lat3_latency", 64'(cyc - acc3), 64'd3);
      chk("lat3_rsp_valid", 64'(t3_rsp_valid), 64'd1);
      chk("lat3_rsp_Y", 64'(t3_rsp_Y), 64'hFFFF_0000);
      chk("lat3_rsp_meta", 64'({t3_rsp_id, t3_rsp_err, t3_rsp_flags}), 64'b000100);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
